// File: rtl/hazard_unit.sv
// Pipeline control for the 16-bit five-stage CPU. Handles load-use bubbles, branch
// flushes, multi-cycle EX stalls and the HALT drain sequence, with a saturating stall counter.
module hazard_unit #(
    parameter int MULTI_CYCLES = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        ex_multi,
    input  logic        ex_branch_taken,
    output logic        pc_mux_sel,
    output logic        pc_stop,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {S_RUN, S_MULTI, S_DRAIN, S_HALTED} state_e;

    localparam logic [3:0] MULTI_INIT = 4'(MULTI_CYCLES - 2);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_q, stall_d;
    logic        load_use;

    assign load_use = ex_mem_read &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (ex_branch_taken) begin
                    state_d = S_RUN;
                end else if (ex_multi) begin
                    state_d = S_MULTI;
                    cnt_d   = MULTI_INIT;
                end else if (!load_use && id_halt) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            S_MULTI: begin
                if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
                else             state_d = S_RUN;
            end
            S_DRAIN: begin
                if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
                else             state_d = S_HALTED;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // Outputs are gated by reset so the pipeline sees no control while reset is held.
    always_comb begin
        pc_mux_sel   = 1'b0;
        pc_stop      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            unique case (state_q)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        pc_mux_sel  = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_multi) begin
                        pc_stop      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (load_use || id_halt) begin
                        pc_stop     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                S_MULTI: begin
                    if (cnt_q != '0) begin
                        pc_stop      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                    end
                end
                S_DRAIN, S_HALTED: begin
                    pc_stop     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted_d = (state_d == S_HALTED);
    assign stall_d  = (pc_stop && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

    assign halted      = halted_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default instance and a MULTI_CYCLES=2 instance share
// stimulus; expectations are queued when inputs are driven and popped at the falling edge.
module tb_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_halt, ex_mem_read, ex_multi, ex_branch_taken;

    logic        pc_mux_sel, pc_stop, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush;
    logic        halted;
    logic [15:0] stall_count;
    logic        pc_mux_sel2, pc_stop2, if_id_hold2, if_id_flush2, id_ex_hold2, id_ex_flush2, ex_mem_flush2;
    logic        halted2;
    logic [15:0] stall_count2;

    always #5 clock = ~clock;

    hazard_unit u_dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_multi(ex_multi),
        .ex_branch_taken(ex_branch_taken),
        .pc_mux_sel(pc_mux_sel), .pc_stop(pc_stop), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted), .stall_count(stall_count)
    );

    hazard_unit #(.MULTI_CYCLES(2), .DRAIN_CYCLES(3)) u_dut2 (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_multi(ex_multi),
        .ex_branch_taken(ex_branch_taken),
        .pc_mux_sel(pc_mux_sel2), .pc_stop(pc_stop2), .if_id_hold(if_id_hold2),
        .if_id_flush(if_id_flush2), .id_ex_hold(id_ex_hold2), .id_ex_flush(id_ex_flush2),
        .ex_mem_flush(ex_mem_flush2), .halted(halted2), .stall_count(stall_count2)
    );

    // Control vector: {pc_mux_sel, pc_stop, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] BR   = 7'b1001010;
    localparam logic [6:0] MUL  = 7'b0110101;
    localparam logic [6:0] STOP = 7'b0110010;

    logic [6:0] ctl1, ctl2;
    assign ctl1 = {pc_mux_sel, pc_stop, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush};
    assign ctl2 = {pc_mux_sel2, pc_stop2, if_id_hold2, if_id_flush2, id_ex_hold2, id_ex_flush2, ex_mem_flush2};

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [6:0]  ctl2;
        logic        halted;
        logic [15:0] stall;
        logic [15:0] stall2;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] stall_m  = '0;
    logic [15:0] stall_m2 = '0;

    function automatic logic [15:0] sat_add(input logic [15:0] v, input int n);
        int s;
        s = int'(v) + n;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic check_head();
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (ctl1 === e.ctl) else begin
            errors++; $error("FAIL %s ctl got %b want %b", e.tag, ctl1, e.ctl);
        end
        checks++;
        assert (ctl2 === e.ctl2) else begin
            errors++; $error("FAIL %s ctl_m2 got %b want %b", e.tag, ctl2, e.ctl2);
        end
        checks++;
        assert (halted === e.halted && halted2 === e.halted) else begin
            errors++; $error("FAIL %s halted got %b/%b want %b", e.tag, halted, halted2, e.halted);
        end
        checks++;
        assert (stall_count === e.stall) else begin
            errors++; $error("FAIL %s stall_count got %h want %h", e.tag, stall_count, e.stall);
        end
        checks++;
        assert (stall_count2 === e.stall2) else begin
            errors++; $error("FAIL %s stall_count_m2 got %h want %h", e.tag, stall_count2, e.stall2);
        end
    endtask

    task automatic set_in(input logic [3:0] rs, input logic urs, input logic [3:0] rt, input logic urt,
                          input logic mr, input logic [3:0] rd, input logic multi,
                          input logic br, input logic halt);
        id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; ex_multi = multi; ex_branch_taken = br; id_halt = halt;
    endtask

    task automatic idle_in();
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a rising edge; checks this cycle, then advances the stall model.
    task automatic step(input string tag, input logic [6:0] c, input logic [6:0] c2, input logic h);
        exp_q.push_back('{tag: tag, ctl: c, ctl2: c2, halted: h, stall: stall_m, stall2: stall_m2});
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
        stall_m  = sat_add(stall_m, int'(c[5]));
        stall_m2 = sat_add(stall_m2, int'(c2[5]));
    endtask

    task automatic run_halted(input int n);
        repeat (n) @(posedge clock);
        #1;
        stall_m  = sat_add(stall_m, n);
        stall_m2 = sat_add(stall_m2, n);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        idle_in();
        stall_m  = '0;
        stall_m2 = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with hazards asserted: outputs must stay gated off.
        reset = 1'b0;
        set_in(4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        exp_q.push_back('{tag: "in_reset", ctl: NONE, ctl2: NONE, halted: 1'b0, stall: 16'd0, stall2: 16'd0});
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_in();

        for (int i = 0; i < 10; i++) step("idle", NONE, NONE, 1'b0);

        // Load-use detection
        set_in(4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step("lu_rs", STOP, STOP, 1'b0);
        idle_in();
        step("lu_after", NONE, NONE, 1'b0);
        set_in(4'd3, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step("lu_rt_r0", STOP, STOP, 1'b0);
        set_in(4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step("lu_unused", NONE, NONE, 1'b0);
        set_in(4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        step("lu_noload", NONE, NONE, 1'b0);
        set_in(4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        step("lu_rt_miss", NONE, NONE, 1'b0);

        // Multi-cycle EX held four cycles; the 2-cycle instance restarts on the third.
        reset_pulse();
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step("multi_c1", MUL, MUL, 1'b0);
        step("multi_c2", MUL, NONE, 1'b0);
        step("multi_c3", MUL, MUL, 1'b0);
        step("multi_c4", NONE, NONE, 1'b0);
        idle_in();
        step("multi_done", NONE, NONE, 1'b0);

        // Branch overrides halt and load-use
        set_in(4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
        step("br_prio", BR, BR, 1'b0);
        idle_in();
        step("br_stays_run", NONE, NONE, 1'b0);

        // Branch/halt ignored while in MULTI
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step("mbr_start", MUL, MUL, 1'b0);
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        step("mbr_ignored", MUL, NONE, 1'b0);
        idle_in();
        step("mbr_last", MUL, NONE, 1'b0);
        step("mbr_release", NONE, NONE, 1'b0);
        step("mbr_idle", NONE, NONE, 1'b0);

        // HALT drain and stop
        reset_pulse();
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("halt_id", STOP, STOP, 1'b0);
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        step("drain_1", STOP, STOP, 1'b0);
        idle_in();
        step("drain_2", STOP, STOP, 1'b0);
        step("drain_3", STOP, STOP, 1'b0);
        step("halted_1", STOP, STOP, 1'b1);
        step("halted_2", STOP, STOP, 1'b1);

        // Asynchronous reset mid-cycle clears everything at once
        reset = 1'b0;
        stall_m  = '0;
        stall_m2 = '0;
        exp_q.push_back('{tag: "async_rst", ctl: NONE, ctl2: NONE, halted: 1'b0, stall: 16'd0, stall2: 16'd0});
        #1;
        check_head();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step("after_rst", NONE, NONE, 1'b0);

        // Saturation through a long HALTED run
        reset_pulse();
        set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step("sat_halt", STOP, STOP, 1'b0);
        idle_in();
        for (int i = 0; i < 3; i++) step("sat_drain", STOP, STOP, 1'b0);
        run_halted(int'(16'hFFFD) - int'(stall_m));
        step("sat_fffd", STOP, STOP, 1'b1);
        step("sat_fffe", STOP, STOP, 1'b1);
        step("sat_ffff", STOP, STOP, 1'b1);
        step("sat_hold", STOP, STOP, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
